// File: rtl/spike_event_if.sv
// Weighted spike event stream feeding the output-layer membrane accumulator.
// The producer drives valid/class/weight; the accumulator answers with ready.
interface spike_event_if #(
  parameter int BIT_WIDTH_WEIGHT = 8
);
  logic                               in_valid_i;
  logic                               in_ready_o;
  logic        [3:0]                  in_class_i;
  logic signed [BIT_WIDTH_WEIGHT-1:0] in_weight_i;

  modport master (
    output in_valid_i,
    output in_class_i,
    output in_weight_i,
    input  in_ready_o
  );

  modport slave (
    input  in_valid_i,
    input  in_class_i,
    input  in_weight_i,
    output in_ready_o
  );
endinterface

// File: rtl/output_membrane_accumulator.sv
// Output-layer membrane accumulator: adds weighted spike events into ten
// saturating signed class membranes over TIMESTEP steps, then freezes them
// and flags them valid for the combinational winner comparator downstream.
module output_membrane_accumulator #(
  parameter int BIT_WIDTH_BIG_MEMBRANE = 16,
  parameter int BIT_WIDTH_WEIGHT       = 8,
  parameter int TIMESTEP               = 8,
  parameter int BIT_WIDTH_TIMESTEP     = 4
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     start_i,
  spike_event_if.slave                             evt,
  input  logic                                     step_done_i,
  input  logic                                     result_ack_i,
  output logic signed [BIT_WIDTH_BIG_MEMBRANE-1:0] variable0_o,
  output logic signed [BIT_WIDTH_BIG_MEMBRANE-1:0] variable1_o,
  output logic signed [BIT_WIDTH_BIG_MEMBRANE-1:0] variable2_o,
  output logic signed [BIT_WIDTH_BIG_MEMBRANE-1:0] variable3_o,
  output logic signed [BIT_WIDTH_BIG_MEMBRANE-1:0] variable4_o,
  output logic signed [BIT_WIDTH_BIG_MEMBRANE-1:0] variable5_o,
  output logic signed [BIT_WIDTH_BIG_MEMBRANE-1:0] variable6_o,
  output logic signed [BIT_WIDTH_BIG_MEMBRANE-1:0] variable7_o,
  output logic signed [BIT_WIDTH_BIG_MEMBRANE-1:0] variable8_o,
  output logic signed [BIT_WIDTH_BIG_MEMBRANE-1:0] variable9_o,
  output logic                                     membrane_valid_o,
  output logic        [BIT_WIDTH_TIMESTEP-1:0]     step_count_o,
  output logic                                     error_o
);

  localparam int W          = BIT_WIDTH_BIG_MEMBRANE;
  localparam int NUM_CLASS  = 10;

  localparam logic signed [W-1:0] MEM_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MEM_MIN = {1'b1, {(W-1){1'b0}}};

  localparam logic [BIT_WIDTH_TIMESTEP-1:0] LAST_STEP  = BIT_WIDTH_TIMESTEP'(TIMESTEP - 1);
  localparam logic [BIT_WIDTH_TIMESTEP-1:0] FINAL_STEP = BIT_WIDTH_TIMESTEP'(TIMESTEP);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  state_t                state;
  logic                  ready;
  logic signed [W-1:0]   mem [NUM_CLASS];

  logic                  class_ok;
  logic signed [W-1:0]   cur_mem;
  logic signed [W:0]     sum;
  logic signed [W-1:0]   sat_sum;

  // Read the addressed membrane and form its saturated update.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    class_ok = (evt.in_class_i < 4'd10);
    cur_mem  = '0;
    sat_sum  = '0;
    if (class_ok) cur_mem = mem[evt.in_class_i];
    // One extra bit of headroom so overflow shows up as a sign disagreement.
    sum = (W+1)'(cur_mem) + (W+1)'(evt.in_weight_i);
    if (sum[W] != sum[W-1]) sat_sum = sum[W] ? MEM_MIN : MEM_MAX;
    else                    sat_sum = sum[W-1:0];
  end

  // Control FSM, step counter, flags and the single membrane write path.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; a same-class event on the next cycle reads the
    // freshly written membrane through the register, with no bypass needed.
    if (reset) begin
      state            <= IDLE;
      ready            <= 1'b0;
      membrane_valid_o <= 1'b0;
      step_count_o     <= '0;
      error_o          <= 1'b0;
      // NOTE: the membrane array is reset explicitly because an aborted
      // inference must leave no partial result on the outputs.
      for (int k = 0; k < NUM_CLASS; k++) mem[k] <= '0;
    end else if (start_i) begin
      // Start wins in every state and discards any same-cycle event or step.
      state            <= ACCUM;
      ready            <= 1'b1;
      membrane_valid_o <= 1'b0;
      step_count_o     <= '0;
      error_o          <= 1'b0;
      for (int k = 0; k < NUM_CLASS; k++) mem[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          ready <= 1'b0;
        end
        ACCUM: begin
          if (evt.in_valid_i && ready) begin
            if (class_ok) begin
              for (int k = 0; k < NUM_CLASS; k++) begin
                if (evt.in_class_i == 4'(k)) mem[k] <= sat_sum;
              end
            end else begin
              error_o <= 1'b1;
            end
          end
          if (step_done_i) begin
            if (step_count_o == LAST_STEP) begin
              state            <= HOLD;
              ready            <= 1'b0;
              membrane_valid_o <= 1'b1;
              step_count_o     <= FINAL_STEP;
            end else begin
              step_count_o <= step_count_o + 1'b1;
            end
          end
        end
        HOLD: begin
          if (result_ack_i) begin
            state            <= IDLE;
            membrane_valid_o <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b0;
        end
      endcase
    end
  end

  assign evt.in_ready_o = ready;

  assign variable0_o = mem[0];
  assign variable1_o = mem[1];
  assign variable2_o = mem[2];
  assign variable3_o = mem[3];
  assign variable4_o = mem[4];
  assign variable5_o = mem[5];
  assign variable6_o = mem[6];
  assign variable7_o = mem[7];
  assign variable8_o = mem[8];
  assign variable9_o = mem[9];

endmodule

// File: tb/tb_output_membrane_accumulator.sv
// Directed testbench for output_membrane_accumulator (TIMESTEP=2, W=16).
module tb_output_membrane_accumulator;

  localparam int W  = 16;
  localparam int WW = 8;
  localparam int TS = 2;
  localparam int BT = 4;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic step_done;
  logic result_ack;

  logic signed [W-1:0] v0, v1, v2, v3, v4, v5, v6, v7, v8, v9;
  logic                membrane_valid;
  logic [BT-1:0]       step_count;
  logic                error;

  wire signed [W-1:0] vars [10];
  assign vars[0] = v0;
  assign vars[1] = v1;
  assign vars[2] = v2;
  assign vars[3] = v3;
  assign vars[4] = v4;
  assign vars[5] = v5;
  assign vars[6] = v6;
  assign vars[7] = v7;
  assign vars[8] = v8;
  assign vars[9] = v9;

  int checks = 0;
  int errors = 0;

  spike_event_if #(.BIT_WIDTH_WEIGHT(WW)) evt ();

  output_membrane_accumulator #(
    .BIT_WIDTH_BIG_MEMBRANE(W),
    .BIT_WIDTH_WEIGHT      (WW),
    .TIMESTEP              (TS),
    .BIT_WIDTH_TIMESTEP    (BT)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start_i         (start),
    .evt             (evt.slave),
    .step_done_i     (step_done),
    .result_ack_i    (result_ack),
    .variable0_o     (v0),
    .variable1_o     (v1),
    .variable2_o     (v2),
    .variable3_o     (v3),
    .variable4_o     (v4),
    .variable5_o     (v5),
    .variable6_o     (v6),
    .variable7_o     (v7),
    .variable8_o     (v8),
    .variable9_o     (v9),
    .membrane_valid_o(membrane_valid),
    .step_count_o    (step_count),
    .error_o         (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled at +1.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic send(input logic [3:0] cls, input logic signed [WW-1:0] w);
    evt.in_valid_i  = 1'b1;
    evt.in_class_i  = cls;
    evt.in_weight_i = w;
    cycle();
    evt.in_valid_i  = 1'b0;
  endtask

  task automatic pulse_step();
    step_done = 1'b1;
    cycle();
    step_done = 1'b0;
  endtask

  // Expect every membrane to equal exp except the listed class (which gets exp_sel).
  task automatic check_all(input string tag, input int sel, input int exp_sel, input int exp);
    for (int k = 0; k < 10; k++)
      check($sformatf("%s_v%0d", tag, k), vars[k], (k == sel) ? exp_sel : exp);
  endtask

  // Index of the first strictly largest membrane, as the comparator picks it.
  function automatic int argmax();
    int best = 0;
    for (int k = 1; k < 10; k++)
      if (vars[k] > vars[best]) best = k;
    return best;
  endfunction

  initial begin
    reset           = 1'b1;
    start           = 1'b0;
    step_done       = 1'b0;
    result_ack      = 1'b0;
    evt.in_valid_i  = 1'b0;
    evt.in_class_i  = '0;
    evt.in_weight_i = '0;

    // Reset state
    #1;
    check_all("rst", 0, 0, 0);
    check("rst_ready", evt.in_ready_o, 0);
    check("rst_valid", membrane_valid, 0);
    check("rst_step", step_count, 0);
    check("rst_err", error, 0);
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
    check("idle_ready", evt.in_ready_o, 0);

    // Reset mid-ACCUM after three events aborts asynchronously
    pulse_start();
    check("accum_ready", evt.in_ready_o, 1);
    send(4'd0, 8'sd1);
    send(4'd1, 8'sd2);
    send(4'd2, 8'sd3);
    check("pre_abort_v2", v2, 3);
    pulse_step();
    check("pre_abort_step", step_count, 1);
    #2;
    reset = 1'b1;
    #1;
    check_all("abort", 0, 0, 0);
    check("abort_ready", evt.in_ready_o, 0);
    check("abort_step", step_count, 0);
    #1;
    reset = 1'b0;
    cycle();
    cycle();
    check("post_abort_ready", evt.in_ready_o, 0);

    // Accumulation and handoff
    pulse_start();
    send(4'd3, 8'sd5);
    check("b2b_first_v3", v3, 5);
    send(4'd3, 8'sd7);
    send(4'd8, -8'sd4);
    pulse_step();
    check("step1_count", step_count, 1);
    check("step1_valid", membrane_valid, 0);
    pulse_step();
    check("hand_valid", membrane_valid, 1);
    check("hand_step", step_count, TS);
    check("hand_ready", evt.in_ready_o, 0);
    for (int k = 0; k < 10; k++)
      check($sformatf("hand_v%0d", k), vars[k], (k == 3) ? 12 : (k == 8) ? -4 : 0);
    check("hand_winner", argmax(), 3);

    // Handshake in HOLD: events and steps ignored
    evt.in_valid_i  = 1'b1;
    evt.in_class_i  = 4'd3;
    evt.in_weight_i = 8'sd5;
    step_done       = 1'b1;
    #1;
    check("hold_ready", evt.in_ready_o, 0);
    cycle();
    cycle();
    evt.in_valid_i = 1'b0;
    step_done      = 1'b0;
    check("hold_v3", v3, 12);
    check("hold_step", step_count, TS);
    check("hold_valid", membrane_valid, 1);
    result_ack = 1'b1;
    cycle();
    result_ack = 1'b0;
    check("ack_valid", membrane_valid, 0);
    check("ack_ready", evt.in_ready_o, 0);
    check("ack_keep_v3", v3, 12);
    check("ack_keep_v8", v8, -4);

    // Saturation, back-to-back to the same class
    pulse_start();
    check("restart_v3", v3, 0);
    evt.in_valid_i  = 1'b1;
    evt.in_class_i  = 4'd0;
    evt.in_weight_i = 8'sd127;
    for (int i = 0; i < 300; i++) begin
      cycle();
      if (i == 1) check("sat_b2b_254", v0, 254);
    end
    check("sat_pos", v0, 32767);
    evt.in_class_i  = 4'd1;
    evt.in_weight_i = -8'sd128;
    for (int i = 0; i < 300; i++) cycle();
    evt.in_valid_i = 1'b0;
    check("sat_neg", v1, -32768);
    check("sat_pos_kept", v0, 32767);
    send(4'd0, -8'sd1);
    check("sat_pos_back", v0, 32766);

    // Invalid class
    send(4'd12, 8'sd9);
    check("bad_err", error, 1);
    check("bad_v0", v0, 32766);
    check("bad_v1", v1, -32768);
    check("bad_v2", v2, 0);

    // Event coincident with the final step
    pulse_step();
    evt.in_valid_i  = 1'b1;
    evt.in_class_i  = 4'd2;
    evt.in_weight_i = 8'sd1;
    step_done       = 1'b1;
    cycle();
    evt.in_valid_i = 1'b0;
    step_done      = 1'b0;
    check("coin_v2", v2, 1);
    check("coin_valid", membrane_valid, 1);
    check("coin_ready", evt.in_ready_o, 0);
    check("hold_err", error, 1);

    // start and result_ack together in HOLD: start wins
    start      = 1'b1;
    result_ack = 1'b1;
    cycle();
    start      = 1'b0;
    result_ack = 1'b0;
    check("sa_ready", evt.in_ready_o, 1);
    check("sa_valid", membrane_valid, 0);
    check("sa_err", error, 0);
    check("sa_step", step_count, 0);
    check_all("sa", 0, 0, 0);

    // start in ACCUM discards a same-cycle event
    send(4'd4, 8'sd10);
    check("acc_v4", v4, 10);
    evt.in_valid_i  = 1'b1;
    evt.in_class_i  = 4'd4;
    evt.in_weight_i = 8'sd10;
    start           = 1'b1;
    step_done       = 1'b1;
    cycle();
    start          = 1'b0;
    step_done      = 1'b0;
    evt.in_valid_i = 1'b0;
    check("restart_v4", v4, 0);
    check("restart_step", step_count, 0);
    check("restart_ready", evt.in_ready_o, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
